mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data Memory port between instruction fetch (IF) and

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single unified instruction/data Memory port between the
//   instruction-fetch (IF) requester and the load/store (D) requester.
//   Fixed priority D over IF, with a starvation guard that forces an IF grant
//   after STARVE_LIMIT consecutive D grants taken while IF was waiting.
//   Every transaction runs IDLE -> ISSUE -> DONE (3 cycles); Memory control
//   and address are registered, Result is captured at the end of ISSUE and
//   returned with a 1-cycle ack in DONE.
//
// Optional feature (macro MEM_ARB_FAULT_EN):
//   Screens the winning request in IDLE (IF address above IMEM_TOP-1, D store
//   into the instruction region, odd address). A faulting request skips
//   Memory entirely and gets fault + its ack in the following cycle.
//   Without the macro the fault port does not exist.
//
// Ports
//   clk, rest                      clock, synchronous active-high reset
//   if_req/if_addr                 fetch request and byte address
//   if_ack/if_rdata                fetch ack pulse and fetched word
//   d_req/d_we/d_addr/d_wdata      data request, store flag, address, store data
//   d_ack/d_rdata                  data ack pulse and loaded word
//   mem_address/mem_read/mem_write/mem_write_data   registered Memory controls
//   mem_result                     combinational Memory Result
//   busy                           high whenever the FSM is not in IDLE
//   fault                          (MEM_ARB_FAULT_EN only) screening fault pulse
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned IMEM_TOP     = 1023
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_result,
    output logic              busy
`ifdef MEM_ARB_FAULT_EN
    ,
    output logic              fault
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_FAULT} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t            r_state;
    logic [2:0]        r_starve_cnt;
    logic              r_sel_d;      // current grant belongs to D
    logic              r_d_we;       // current D grant is a store
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_mem_write_data;
    logic              r_busy;
    logic              w_any_req;
    logic              w_pick_d;

    assign w_any_req = if_req | d_req;
    // D wins unless IF is waiting and has already been passed over LIMIT times
    assign w_pick_d  = d_req & ~(if_req & (r_starve_cnt == LIMIT));

`ifdef MEM_ARB_FAULT_EN
    localparam logic [ADDR_W-1:0] IMEM_TOP_A  = ADDR_W'(IMEM_TOP);
    localparam logic [ADDR_W-1:0] IMEM_LAST_A = ADDR_W'(IMEM_TOP - 1);

    logic w_fault;
    logic r_fault;

    always_comb begin
        if (w_pick_d)
            w_fault = (d_we & (d_addr <= IMEM_TOP_A)) | d_addr[0];
        else
            w_fault = (if_addr > IMEM_LAST_A) | if_addr[0];
    end

    assign fault = r_fault;
`endif

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state          <= S_IDLE;
            r_starve_cnt     <= '0;
            r_sel_d          <= 1'b0;
            r_d_we           <= 1'b0;
            r_if_ack         <= 1'b0;
            r_d_ack          <= 1'b0;
            r_if_rdata       <= '0;
            r_d_rdata        <= '0;
            r_mem_address    <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_write_data <= '0;
            r_busy           <= 1'b0;
`ifdef MEM_ARB_FAULT_EN
            r_fault          <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel_d <= w_pick_d;
                        r_d_we  <= w_pick_d & d_we;
                        r_busy  <= 1'b1;
                        if (w_pick_d) begin
                            if (if_req && r_starve_cnt != LIMIT)
                                r_starve_cnt <= r_starve_cnt + 3'd1;
                        end else begin
                            r_starve_cnt <= '0;
                        end
`ifdef MEM_ARB_FAULT_EN
                        if (w_fault) begin
                            // Screened out: Memory is never driven, ack comes next cycle
                            r_state  <= S_FAULT;
                            r_fault  <= 1'b1;
                            r_d_ack  <= w_pick_d;
                            r_if_ack <= ~w_pick_d;
                        end else
`endif
                        begin
                            r_state       <= S_ISSUE;
                            r_mem_address <= w_pick_d ? d_addr : if_addr;
                            r_mem_read    <= w_pick_d & ~d_we;
                            r_mem_write   <= w_pick_d & d_we;
                            if (w_pick_d)
                                r_mem_write_data <= d_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (!r_sel_d)
                        r_if_rdata <= mem_result;
                    else if (!r_d_we)
                        r_d_rdata <= mem_result;
                    r_if_ack <= ~r_sel_d;
                    r_d_ack  <= r_sel_d;
                    r_state  <= S_DONE;
                end
                S_DONE, S_FAULT: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_busy   <= 1'b0;
`ifdef MEM_ARB_FAULT_EN
                    r_fault  <= 1'b0;
`endif
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_ack         = r_if_ack;
    assign if_rdata       = r_if_rdata;
    assign d_ack          = r_d_ack;
    assign d_rdata        = r_d_rdata;
    assign mem_address    = r_mem_address;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_write_data = r_mem_write_data;
    assign busy           = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a byte-addressed big-endian Memory
//   model: fetch-mode accesses above 1023 return 0, stores land on posedge.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rest;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_write_data;
    logic [15:0] mem_result;
    logic        busy;
`ifdef MEM_ARB_FAULT_EN
    logic        fault;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3), .IMEM_TOP(1023)) dut (
        .clk(clk), .rest(rest),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_result(mem_result), .busy(busy)
`ifdef MEM_ARB_FAULT_EN
        , .fault(fault)
`endif
    );

    // Memory model
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address]         <= mem_write_data[15:8];
            mem[mem_address + 16'd1] <= mem_write_data[7:0];
        end
    end
    assign mem_result = (!mem_read && !mem_write && mem_address > 16'd1023) ? 16'h0000
                      : {mem[mem_address], mem[mem_address + 16'd1]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rest = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        vectors++; if ({if_ack, d_ack, busy, mem_read, mem_write} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b expected 00000", {if_ack, d_ack, busy, mem_read, mem_write}); end
        vectors++; if (mem_address !== 16'h0 || mem_write_data !== 16'h0) begin miscompares++; $display("FAIL reset_mem: got addr %h wdata %h expected 0000 0000", mem_address, mem_write_data); end
        vectors++; if (if_rdata !== 16'h0 || d_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h %h expected 0000 0000", if_rdata, d_rdata); end
        rest = 1'b0;
    endtask

    task automatic test_fetch();
        logic [15:0] addrs [2];
        logic [15:0] exp   [2];
        addrs[0] = 16'h0000; exp[0] = 16'h0810;
        addrs[1] = 16'h0002; exp[1] = 16'h2310;
        for (int i = 0; i < 2; i++) begin
            if_req = 1'b1; if_addr = addrs[i];
            tick();   // sampling edge -> ISSUE
            vectors++; if ({busy, mem_read, mem_write, if_ack} !== 4'b1000 || mem_address !== addrs[i]) begin miscompares++; $display("FAIL fetch_issue%0d: got busy/rd/wr/ack %b addr %h expected 1000 %h", i, {busy, mem_read, mem_write, if_ack}, mem_address, addrs[i]); end
            tick();   // -> DONE
            vectors++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== exp[i]) begin miscompares++; $display("FAIL fetch_done%0d: got ack %b/%b rdata %h expected 1/0 %h", i, if_ack, d_ack, if_rdata, exp[i]); end
            if_req = 1'b0;
            tick();   // -> IDLE
            vectors++; if (if_ack !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL fetch_idle%0d: got ack %b busy %b expected 0 0", i, if_ack, busy); end
        end
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 16'hBEEF;
        tick();
        vectors++; if ({mem_read, mem_write} !== 2'b01 || mem_address !== 16'h0400 || mem_write_data !== 16'hBEEF) begin miscompares++; $display("FAIL store_issue: got rd/wr %b addr %h wdata %h expected 01 0400 beef", {mem_read, mem_write}, mem_address, mem_write_data); end
        tick();
        vectors++; if (mem_write !== 1'b0 || d_ack !== 1'b1) begin miscompares++; $display("FAIL store_done: got wr %b ack %b expected 0 1", mem_write, d_ack); end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0;
        tick();
        vectors++; if ({mem_read, mem_write} !== 2'b10 || mem_address !== 16'h0400) begin miscompares++; $display("FAIL load_issue: got rd/wr %b addr %h expected 10 0400", {mem_read, mem_write}, mem_address); end
        tick();
        vectors++; if (d_ack !== 1'b1 || d_rdata !== 16'hBEEF || mem_read !== 1'b0) begin miscompares++; $display("FAIL load_done: got ack %b rdata %h rd %b expected 1 beef 0", d_ack, d_rdata, mem_read); end
        vectors++; if (if_rdata !== 16'h2310) begin miscompares++; $display("FAIL if_rdata_hold: got %h expected 2310", if_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic exp_d;
        logic got_d;
        int   waited;
        if_req = 1'b1; if_addr = 16'h0000;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
        for (int g = 0; g < 8; g++) begin
            exp_d  = (g % 4) != 3;
            waited = 0;
            while (!(if_ack || d_ack) && waited < 6) begin
                tick();
                waited++;
            end
            got_d = d_ack;
            vectors++; if (!(if_ack || d_ack) || (if_ack && d_ack) || got_d !== exp_d) begin miscompares++; $display("FAIL grant%0d: got if_ack %b d_ack %b expected d_ack %b only", g, if_ack, d_ack, exp_d); end
            if (exp_d) begin
                vectors++; if (d_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL grant%0d_data: got %h expected beef", g, d_rdata); end
            end else begin
                vectors++; if (if_rdata !== 16'h0810) begin miscompares++; $display("FAIL grant%0d_data: got %h expected 0810", g, if_rdata); end
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_store();
        logic saw_ack;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0402; d_wdata = 16'h1234;
        tick();
        vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rst_store_issue: got wr %b expected 1", mem_write); end
        rest = 1'b1; d_req = 1'b0;
        tick();
        vectors++; if ({busy, mem_write, mem_read, d_ack} !== 4'b0 || mem_address !== 16'h0) begin miscompares++; $display("FAIL rst_mid: got busy/wr/rd/ack %b addr %h expected 0000 0000", {busy, mem_write, mem_read, d_ack}, mem_address); end
        rest = 1'b0;
        saw_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            saw_ack = saw_ack | d_ack | busy;
        end
        vectors++; if (saw_ack !== 1'b0) begin miscompares++; $display("FAIL rst_no_ack: got activity %b expected 0", saw_ack); end
    endtask

`ifdef MEM_ARB_FAULT_EN
    task automatic test_fault();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hAAAA;
        tick();
        vectors++; if ({fault, d_ack, mem_write, if_ack} !== 4'b1100) begin miscompares++; $display("FAIL fault_store: got fault/dack/wr/iack %b expected 1100", {fault, d_ack, mem_write, if_ack}); end
        d_req = 1'b0;
        tick();
        vectors++; if ({fault, d_ack, busy, mem_write} !== 4'b0 || d_rdata !== 16'h0) begin miscompares++; $display("FAIL fault_store_end: got %b rdata %h expected 0000 0000", {fault, d_ack, busy, mem_write}, d_rdata); end
        if_req = 1'b1; if_addr = 16'h0003;
        tick();
        vectors++; if ({fault, if_ack, mem_read, mem_write} !== 4'b1100 || if_rdata !== 16'h0) begin miscompares++; $display("FAIL fault_odd_if: got %b rdata %h expected 1100 0000", {fault, if_ack, mem_read, mem_write}, if_rdata); end
        if_req = 1'b0;
        tick();
        vectors++; if ({fault, if_ack, busy} !== 3'b0) begin miscompares++; $display("FAIL fault_if_end: got %b expected 000", {fault, if_ack, busy}); end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[0] = 8'h08; mem[1] = 8'h10; mem[2] = 8'h23; mem[3] = 8'h10;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_reset_mid_store();
`ifdef MEM_ARB_FAULT_EN
        test_fault();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
